// File: rtl/sram_like_arbiter_pkg.sv
// Shared definitions for the SRAM-like two-port arbiter.
//   PORT_INST / PORT_DATA : requester identifiers, stored in the ID FIFO.
//   OUTST_DEPTH_DEF       : default depth of the outstanding-request FIFO.
//   lock_state_e          : address-phase lock FSM states.
package sram_like_arbiter_pkg;

  localparam logic PORT_INST = 1'b0;
  localparam logic PORT_DATA = 1'b1;

  localparam int unsigned OUTST_DEPTH_DEF = 4;

  typedef enum logic {
    LOCK_UNLOCKED = 1'b0,
    LOCK_LOCKED   = 1'b1
  } lock_state_e;

endpackage

// File: rtl/sram_like_arbiter_id.sv
// arb_id_fifo: 1-bit-wide synchronous FIFO recording the owner of each
// accepted downstream request.
//   clk, resetn     : clock, asynchronous active-low reset
//   push, push_id   : enqueue push_id (ignored when full)
//   pop             : dequeue head (ignored when empty)
//   head            : owner at the FIFO head
//   full, empty     : occupancy flags
//   count           : current occupancy (0..DEPTH)
module arb_id_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic             push_id,
  input  logic             pop,
  output logic             head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic             mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  always_comb begin
    full    = (count == CNT_W'(DEPTH));
    empty   = (count == '0);
    do_push = push & ~full;
    do_pop  = pop & ~empty;
    head    = mem[rd_ptr];
  end

  // Pointers are PTR_W bits wide over a power-of-2 depth, so they wrap
  // naturally modulo DEPTH.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= 1'b0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_id;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sram_like_arbiter.sv
// sram_like_arbiter: shares one SRAM-like downstream port between the
// instruction fetch requester (m0, read-only) and the data requester
// (m1, read/write). Data has priority; a request whose address phase is
// stalled by the downstream is locked until accepted. Responses return in
// order and are routed via the ID FIFO.
//   clk, resetn                  : clock, asynchronous active-low reset
//   m0_*                         : inst requester (req/size/addr in, addrok/dataok/rdata out)
//   m1_*                         : data requester (adds wr/wstrb/wdata)
//   s_*                          : downstream request/response port
//   outst_cnt                    : accepted-but-unanswered requests
//   err_orphan                   : sticky, response seen with nothing outstanding
module sram_like_arbiter
  import sram_like_arbiter_pkg::*;
#(
  parameter int unsigned OUTST_DEPTH = OUTST_DEPTH_DEF,
  parameter int unsigned CNT_W       = $clog2(OUTST_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             m0_req,
  input  logic [2:0]       m0_size,
  input  logic [31:0]      m0_addr,
  output logic             m0_addrok,
  output logic             m0_dataok,
  output logic [31:0]      m0_rdata,
  input  logic             m1_req,
  input  logic             m1_wr,
  input  logic [2:0]       m1_size,
  input  logic [31:0]      m1_addr,
  input  logic [3:0]       m1_wstrb,
  input  logic [31:0]      m1_wdata,
  output logic             m1_addrok,
  output logic             m1_dataok,
  output logic [31:0]      m1_rdata,
  output logic             s_req,
  output logic             s_wr,
  output logic [2:0]       s_size,
  output logic [31:0]      s_addr,
  output logic [3:0]       s_wstrb,
  output logic [31:0]      s_wdata,
  input  logic             s_addrok,
  input  logic             s_dataok,
  input  logic [31:0]      s_rdata,
  output logic [CNT_W-1:0] outst_cnt,
  output logic             err_orphan
);

  lock_state_e lock_state, lock_state_nxt;
  logic        lock_id, lock_id_nxt;
  logic        gnt;
  logic        req_sel;
  logic        accept;
  logic        pop;
  logic        fifo_head;
  logic        fifo_full;
  logic        fifo_empty;

  arb_id_fifo #(
    .DEPTH (OUTST_DEPTH),
    .CNT_W (CNT_W)
  ) u_id_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .push    (accept),
    .push_id (gnt),
    .pop     (pop),
    .head    (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (outst_cnt)
  );

  // Grant, downstream request mux and response routing. Handshake outputs
  // are gated by resetn so they are quiet during reset even though the
  // upstream requests may still be asserted.
  always_comb begin
    if (lock_state == LOCK_LOCKED) begin
      gnt = lock_id;
    end else begin
      gnt = m1_req ? PORT_DATA : PORT_INST;
    end

    req_sel = (gnt == PORT_DATA) ? m1_req : m0_req;
    s_req   = resetn & req_sel & ~fifo_full;
    accept  = s_req & s_addrok;

    if (gnt == PORT_DATA) begin
      s_wr    = m1_wr;
      s_size  = m1_size;
      s_addr  = m1_addr;
      s_wstrb = m1_wstrb;
      s_wdata = m1_wdata;
    end else begin
      s_wr    = 1'b0;
      s_size  = m0_size;
      s_addr  = m0_addr;
      s_wstrb = '0;
      s_wdata = '0;
    end

    m0_addrok = accept & (gnt == PORT_INST);
    m1_addrok = accept & (gnt == PORT_DATA);

    pop       = resetn & s_dataok & ~fifo_empty;
    m0_dataok = pop & (fifo_head == PORT_INST);
    m1_dataok = pop & (fifo_head == PORT_DATA);
    m0_rdata  = s_rdata;
    m1_rdata  = s_rdata;
  end

  // Lock FSM: a stalled address phase keeps its owner until accepted.
  // Leaving LOCKED needs an actual accept, so the lock survives a full
  // FIFO (s_req low) even if s_addrok happens to be high.
  always_comb begin
    lock_state_nxt = lock_state;
    lock_id_nxt    = lock_id;
    case (lock_state)
      LOCK_UNLOCKED: begin
        if (s_req && !s_addrok) begin
          lock_state_nxt = LOCK_LOCKED;
          lock_id_nxt    = gnt;
        end
      end
      LOCK_LOCKED: begin
        if (accept) begin
          lock_state_nxt = LOCK_UNLOCKED;
        end
      end
      default: lock_state_nxt = LOCK_UNLOCKED;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lock_state <= LOCK_UNLOCKED;
      lock_id    <= PORT_INST;
      err_orphan <= 1'b0;
    end else begin
      lock_state <= lock_state_nxt;
      lock_id    <= lock_id_nxt;
      if (s_dataok && fifo_empty) begin
        err_orphan <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sram_like_arbiter.sv
module tb_sram_like_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        m0_req;
  logic [2:0]  m0_size;
  logic [31:0] m0_addr;
  logic        m0_addrok, m0_dataok;
  logic [31:0] m0_rdata;
  logic        m1_req, m1_wr;
  logic [2:0]  m1_size;
  logic [31:0] m1_addr;
  logic [3:0]  m1_wstrb;
  logic [31:0] m1_wdata;
  logic        m1_addrok, m1_dataok;
  logic [31:0] m1_rdata;
  logic        s_req, s_wr;
  logic [2:0]  s_size;
  logic [31:0] s_addr;
  logic [3:0]  s_wstrb;
  logic [31:0] s_wdata;
  logic        s_addrok, s_dataok;
  logic [31:0] s_rdata;
  logic [2:0]  outst_cnt;
  logic        err_orphan;

  typedef struct {
    logic        port;
    logic [31:0] rdata;
  } resp_t;

  resp_t sb[$];
  int    n_checks = 0;
  int    n_errors = 0;

  always #5 clk = ~clk;

  sram_like_arbiter dut (
    .clk        (clk),
    .resetn     (resetn),
    .m0_req     (m0_req),
    .m0_size    (m0_size),
    .m0_addr    (m0_addr),
    .m0_addrok  (m0_addrok),
    .m0_dataok  (m0_dataok),
    .m0_rdata   (m0_rdata),
    .m1_req     (m1_req),
    .m1_wr      (m1_wr),
    .m1_size    (m1_size),
    .m1_addr    (m1_addr),
    .m1_wstrb   (m1_wstrb),
    .m1_wdata   (m1_wdata),
    .m1_addrok  (m1_addrok),
    .m1_dataok  (m1_dataok),
    .m1_rdata   (m1_rdata),
    .s_req      (s_req),
    .s_wr       (s_wr),
    .s_size     (s_size),
    .s_addr     (s_addr),
    .s_wstrb    (s_wstrb),
    .s_wdata    (s_wdata),
    .s_addrok   (s_addrok),
    .s_dataok   (s_dataok),
    .s_rdata    (s_rdata),
    .outst_cnt  (outst_cnt),
    .err_orphan (err_orphan)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive point: just after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Downstream response: the bench knows which requester owns it.
  task automatic respond(input logic port, input logic [31:0] data);
    resp_t e;
    s_dataok = 1'b1;
    s_rdata  = data;
    e.port   = port;
    e.rdata  = data;
    sb.push_back(e);
  endtask

  // Response monitor: every mX_dataok must match the scoreboard head.
  always @(negedge clk) begin
    if (resetn && (m0_dataok || m1_dataok)) begin
      if (sb.size() == 0) begin
        chk("dataok_unexpected", {30'd0, m0_dataok, m1_dataok}, 32'd0);
      end else begin
        resp_t e;
        e = sb.pop_front();
        chk("dataok_port", {30'd0, m0_dataok, m1_dataok}, e.port ? 32'd1 : 32'd2);
        chk("rdata", e.port ? m1_rdata : m0_rdata, e.rdata);
      end
    end
  end

  initial begin
    resetn = 1'b0;
    m0_req = 0; m0_size = 3'd2; m0_addr = '0;
    m1_req = 0; m1_wr = 0; m1_size = 3'd2; m1_addr = '0; m1_wstrb = '0; m1_wdata = '0;
    s_addrok = 0; s_dataok = 0; s_rdata = '0;

    // Reset state
    #12;
    chk("rst_s_req", {31'd0, s_req}, 0);
    chk("rst_cnt", {29'd0, outst_cnt}, 0);
    chk("rst_orphan", {31'd0, err_orphan}, 0);
    m0_req = 1;
    #1;
    chk("rst_req_gated", {31'd0, s_req}, 0);
    chk("rst_addrok_gated", {31'd0, m0_addrok}, 0);
    m0_req = 0;
    #2 resetn = 1'b1;

    // Single inst read
    tick();
    m0_req = 1; m0_addr = 32'hBFC0_0000; s_addrok = 1;
    #1;
    chk("t1_s_req", {31'd0, s_req}, 1);
    chk("t1_s_addr", s_addr, 32'hBFC0_0000);
    chk("t1_s_wr", {31'd0, s_wr}, 0);
    chk("t1_m0_addrok", {31'd0, m0_addrok}, 1);
    chk("t1_m1_addrok", {31'd0, m1_addrok}, 0);
    tick();
    m0_req = 0; s_addrok = 0;
    #1;
    chk("t1_cnt1", {29'd0, outst_cnt}, 1);
    tick();
    respond(1'b0, 32'h3C1D_0000);
    #1;
    chk("t1_m0_dataok", {31'd0, m0_dataok}, 1);
    tick();
    s_dataok = 0;
    #1;
    chk("t1_cnt0", {29'd0, outst_cnt}, 0);

    // Simultaneous requests: data first
    tick();
    m0_req = 1; m0_addr = 32'hBFC0_0004;
    m1_req = 1; m1_wr = 1; m1_addr = 32'h8000_1000; m1_wdata = 32'h1234; m1_wstrb = 4'hF;
    s_addrok = 1;
    #1;
    chk("t2_s_wr", {31'd0, s_wr}, 1);
    chk("t2_s_addr_d", s_addr, 32'h8000_1000);
    chk("t2_s_wdata", s_wdata, 32'h1234);
    chk("t2_s_wstrb", {28'd0, s_wstrb}, 32'hF);
    chk("t2_m1_addrok", {31'd0, m1_addrok}, 1);
    chk("t2_m0_addrok0", {31'd0, m0_addrok}, 0);
    tick();
    m1_req = 0;
    #1;
    chk("t2_s_addr_i", s_addr, 32'hBFC0_0004);
    chk("t2_inst_wr0", {31'd0, s_wr}, 0);
    chk("t2_inst_wstrb0", {28'd0, s_wstrb}, 0);
    chk("t2_inst_wdata0", s_wdata, 0);
    chk("t2_m0_addrok", {31'd0, m0_addrok}, 1);
    tick();
    m0_req = 0; s_addrok = 0; m1_wr = 0;
    respond(1'b1, 32'hDEAD_BEEF);
    #1;
    chk("t2_cnt2", {29'd0, outst_cnt}, 2);
    tick();
    respond(1'b0, 32'hAAAA_5555);
    tick();
    s_dataok = 0;
    #1;
    chk("t2_cnt0", {29'd0, outst_cnt}, 0);

    // Stalled inst address phase is locked against a late data request
    tick();
    m0_req = 1; m0_addr = 32'hBFC0_0008; s_addrok = 0;
    #1;
    chk("t3_s_req", {31'd0, s_req}, 1);
    tick();
    m1_req = 1; m1_wr = 0; m1_addr = 32'h8000_2000;
    #1;
    chk("t3_lock_addr1", s_addr, 32'hBFC0_0008);
    chk("t3_m1_addrok1", {31'd0, m1_addrok}, 0);
    tick();
    #1;
    chk("t3_lock_addr2", s_addr, 32'hBFC0_0008);
    tick();
    s_addrok = 1;
    #1;
    chk("t3_m0_addrok", {31'd0, m0_addrok}, 1);
    chk("t3_m1_addrok3", {31'd0, m1_addrok}, 0);
    tick();
    m0_req = 0;
    #1;
    chk("t3_s_addr_d", s_addr, 32'h8000_2000);
    chk("t3_m1_addrok", {31'd0, m1_addrok}, 1);
    tick();
    m1_req = 0; s_addrok = 0;
    respond(1'b0, 32'h1111_1111);
    tick();
    respond(1'b1, 32'h2222_2222);
    tick();
    s_dataok = 0;
    #1;
    chk("t3_cnt0", {29'd0, outst_cnt}, 0);

    // Fill to depth, back-pressure, recovery, same-cycle accept+response
    for (int i = 0; i < 4; i++) begin
      tick();
      m0_req = 1; m0_addr = 32'hBFC0_0100 + 32'(4 * i); s_addrok = 1;
      #1;
      chk("t4_fill_addrok", {31'd0, m0_addrok}, 1);
    end
    tick();
    #1;
    chk("t4_cnt4", {29'd0, outst_cnt}, 4);
    chk("t4_full_s_req", {31'd0, s_req}, 0);
    chk("t4_full_addrok", {31'd0, m0_addrok}, 0);
    respond(1'b0, 32'h0000_0100);
    #1;
    chk("t4_no_bypass", {31'd0, s_req}, 0);
    tick();
    s_dataok = 0;
    #1;
    chk("t4_cnt3", {29'd0, outst_cnt}, 3);
    chk("t4_resume", {31'd0, m0_addrok}, 1);
    tick();
    m0_req = 0;
    respond(1'b0, 32'h0000_0104);
    tick();
    respond(1'b0, 32'h0000_0108);
    tick();
    s_dataok = 0;
    #1;
    chk("t4_cnt2", {29'd0, outst_cnt}, 2);
    m0_req = 1;
    respond(1'b0, 32'h0000_010C);
    #1;
    chk("t4_same_addrok", {31'd0, m0_addrok}, 1);
    tick();
    m0_req = 0; s_addrok = 0;
    s_dataok = 0;
    #1;
    chk("t4_same_cnt2", {29'd0, outst_cnt}, 2);
    tick();
    respond(1'b0, 32'h0000_0110);
    tick();
    respond(1'b0, 32'h0000_0114);
    tick();
    s_dataok = 0;
    #1;
    chk("t4_cnt0", {29'd0, outst_cnt}, 0);

    // Orphan response
    tick();
    s_dataok = 1; s_rdata = 32'h0BAD_0BAD;
    #1;
    chk("t5_orphan_m0", {31'd0, m0_dataok}, 0);
    chk("t5_orphan_m1", {31'd0, m1_dataok}, 0);
    tick();
    s_dataok = 0;
    #1;
    chk("t5_orphan_set", {31'd0, err_orphan}, 1);
    chk("t5_orphan_cnt", {29'd0, outst_cnt}, 0);
    tick();
    #1;
    chk("t5_orphan_sticky", {31'd0, err_orphan}, 1);

    // Asynchronous reset with requests outstanding
    for (int i = 0; i < 3; i++) begin
      tick();
      m0_req = 1; m0_addr = 32'hBFC0_0200 + 32'(4 * i); s_addrok = 1;
    end
    tick();
    #1;
    chk("t6_cnt3", {29'd0, outst_cnt}, 3);
    chk("t6_s_req_pre", {31'd0, s_req}, 1);
    #2 resetn = 1'b0;
    #1;
    chk("t6_rst_cnt", {29'd0, outst_cnt}, 0);
    chk("t6_rst_orphan", {31'd0, err_orphan}, 0);
    chk("t6_rst_s_req", {31'd0, s_req}, 0);
    chk("t6_rst_addrok", {31'd0, m0_addrok}, 0);
    tick();
    m0_req = 0; s_addrok = 0;
    #2 resetn = 1'b1;
    tick();
    #1;
    chk("t6_post_cnt", {29'd0, outst_cnt}, 0);
    chk("sb_drained", 32'(sb.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sram_like_arbiter.md
Name: sram_like_arbiter

Overview:
Shares one downstream SRAM-like memory port (req/addrok/dataok protocol) between the core's instruction-fetch requester (port 0, read-only) and data requester (port 1, read/write). Sits between the CPU core's inst_sram/data_sram interfaces and the single memory bridge. Grants one address phase per cycle and records the owner of each accepted request. In-order downstream data responses are routed back to the owning requester.

Parameters:
OUTST_DEPTH, 4, maximum accepted-but-unanswered downstream requests (ID FIFO depth, power of 2, >=2)
CNT_W, 3, width of outstanding counter (clog2(OUTST_DEPTH)+1)

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
m0_req  in  1  inst request, held until m0_addrok
m0_size  in  3  inst access size
m0_addr  in  32  inst physical address
m0_addrok  out  1  inst address phase accepted
m0_dataok  out  1  inst read data valid
m0_rdata  out  32  inst read data
m1_req  in  1  data request, held until m1_addrok
m1_wr  in  1  data write (1) / read (0)
m1_size  in  3  data access size
m1_addr  in  32  data physical address
m1_wstrb  in  4  data byte strobes
m1_wdata  in  32  data write data
m1_addrok  out  1  data address phase accepted
m1_dataok  out  1  data read data valid / write done
m1_rdata  out  32  data read data
s_req  out  1  downstream request
s_wr  out  1  downstream write
s_size  out  3  downstream size
s_addr  out  32  downstream address
s_wstrb  out  4  downstream strobes
s_wdata  out  32  downstream write data
s_addrok  in  1  downstream address accepted
s_dataok  in  1  downstream response, strictly in request order
s_rdata  in  32  downstream read data
outst_cnt  out  CNT_W  outstanding requests
err_orphan  out  1  sticky: s_dataok seen with nothing outstanding

Behaviour:
- Reset (resetn=0, async): lock=0, lock_id=0, FIFO empty, outst_cnt=0, err_orphan=0. s_req, m0/m1_addrok and m0/m1_dataok are 0 while resetn=0. Any in-flight transaction is abandoned; the downstream side is reset together.
- Grant select, combinational: if lock then gnt=lock_id; else gnt=1 if m1_req, else gnt=0. Data has strict priority over inst.
- Port 0 is read-only: s_wr=0, s_wstrb=0, s_wdata=0 when gnt=0.
- full = (outst_cnt==OUTST_DEPTH). s_req = req[gnt] & ~full. s_wr/s_size/s_addr/s_wstrb/s_wdata muxed from gnt.
- mX_addrok = s_req & s_addrok & (gnt==X). Zero-latency pass-through.
- Lock state machine, states UNLOCKED/LOCKED:
  - UNLOCKED -> LOCKED when s_req & ~s_addrok; lock_id<=gnt. Keeps the address phase stable; a late m1_req cannot steal a pending inst request.
  - LOCKED -> UNLOCKED on s_addrok. Stays LOCKED while full; s_req drops and the lock is held.
- Accept (s_req & s_addrok): push gnt into ID FIFO; outst_cnt+1.
- Response (s_dataok & FIFO non-empty): pop head; m[head]_dataok=1 in the same cycle; outst_cnt-1. s_rdata is broadcast to m0_rdata and m1_rdata; only dataok qualifies it. Writes return dataok on port 1 too.
- Accept and response in the same cycle: push and pop both happen; outst_cnt unchanged; head advances. If full, no accept occurs that cycle even if a pop happens (conservative, no bypass).
- s_dataok while empty: ignored (no dataok out, cnt stays 0), err_orphan<=1 until reset.
- FIFO pointers wrap modulo OUTST_DEPTH. outst_cnt never exceeds OUTST_DEPTH.
- No address-hazard checking. Ordering between ports is the order of acceptance.

Decomposition:
- Shared package: PORT_INST=1'b0, PORT_DATA=1'b1, default OUTST_DEPTH, lock state encoding.
- One sub-module: arb_id_fifo, 1-bit-wide synchronous FIFO (push/pop/full/empty/head, async active-low reset). The arbiter holds the grant/lock logic and muxes.

Test Plan:
- m0_req only, addr 0xBFC00000, s_addrok same cycle, s_dataok 2 cycles later with rdata 0x3C1D0000 -> m0_addrok cycle 0, m0_dataok+m0_rdata=0x3C1D0000 cycle 2, m1_dataok never, outst_cnt 0->1->0.
- m0_req and m1_req (write 0x1234 to 0x80001000, wstrb 0xF) both asserted, s_addrok=1 -> data granted first (s_wr=1, s_addr=0x80001000), inst granted next cycle; dataoks return to port 1 then port 0.
- m0_req with s_addrok held low 3 cycles, m1_req rises in cycle 1 -> s_addr stays the inst address until s_addrok; m1_addrok only afterwards.
- Issue 4 reads with no s_dataok -> outst_cnt=4, s_req=0 despite m0_req. One s_dataok -> cnt 3; next cycle accept resumes. Same-cycle accept+response with cnt=2 -> cnt stays 2.
- s_dataok pulse with outst_cnt=0 -> no mX_dataok, err_orphan=1 and stays set. Assert resetn=0 mid-stream with 3 outstanding -> outst_cnt=0, err_orphan=0, s_req=0 immediately (asynchronous).
